// File: rtl/palette_pkg.sv
// Shared palette definition: per-channel level tables, decision thresholds and index layout.
// Also the single source of the 256-entry palette colour table.
package palette_pkg;

    localparam int RG_N = 7;
    localparam int B_N  = 3;

    // Element 0 sits at the LSB end, so code k selects entry [k].
    localparam logic [RG_N-1:0][7:0] RG_THR = {8'hEF, 8'hC8, 8'hA0, 8'h80, 8'h60, 8'h38, 8'h10};
    localparam logic [RG_N:0][7:0]   RG_LVL = {8'hFF, 8'hE0, 8'hB0, 8'h90, 8'h70, 8'h50, 8'h20, 8'h00};
    localparam logic [B_N-1:0][7:0]  B_THR  = {8'hD7, 8'h80, 8'h28};
    localparam logic [B_N:0][7:0]    B_LVL  = {8'hFF, 8'hB0, 8'h50, 8'h00};

    typedef struct packed {
        logic [2:0] r;
        logic [2:0] g;
        logic [1:0] b;
    } pal_index_t;

    function automatic logic [23:0] palette_rom(input pal_index_t idx);
        return {RG_LVL[idx.r], RG_LVL[idx.g], B_LVL[idx.b]};
    endfunction

endpackage

// File: rtl/palette_quantizer_if.sv
// Pixel-in / index-out streaming bundle of the palette quantizer, plus its frame statistics.
interface palette_quantizer_if #(
    parameter int CNT_W = 20
);
    logic             in_valid;
    logic             in_ready;
    logic [23:0]      in_rgb;
    logic             in_sof;
    logic             out_valid;
    logic             out_ready;
    logic [7:0]       out_index;
    logic             out_exact;
    logic             out_sof;
    logic [CNT_W-1:0] pix_count;
    logic [CNT_W-1:0] exact_count;

    modport master (
        output in_valid, in_rgb, in_sof, out_ready,
        input  in_ready, out_valid, out_index, out_exact, out_sof, pix_count, exact_count
    );

    modport slave (
        input  in_valid, in_rgb, in_sof, out_ready,
        output in_ready, out_valid, out_index, out_exact, out_sof, pix_count, exact_count
    );
endinterface

// File: rtl/palette_channel_quant.sv
// One colour channel: level code = number of thresholds strictly exceeded,
// exact = value sits precisely on the chosen level.
module palette_channel_quant #(
    parameter int N  = 7,
    parameter int CW = 3
) (
    input  logic [7:0]        value_i,
    input  logic [N-1:0][7:0] thr_i,
    input  logic [N:0][7:0]   lvl_i,
    output logic [CW-1:0]     code_o,
    output logic              exact_o
);

    logic [CW-1:0] cnt_s;

    // Thermometer count; a value equal to a threshold stays on the lower level.
    always_comb begin
        cnt_s = {CW{1'b0}};
        for (int k = 0; k < N; k++) begin
            if (value_i > thr_i[k]) begin
                cnt_s = cnt_s + {{(CW-1){1'b0}}, 1'b1};
            end else begin
                cnt_s = cnt_s;
            end
        end
    end

    assign code_o  = cnt_s;
    assign exact_o = (value_i == lvl_i[cnt_s]);

endmodule

// File: rtl/palette_quantizer.sv
// Two-stage RGB888 -> 8-bit palette index quantizer with valid/ready flow control
// and per-frame pixel / exact-match counters.
module palette_quantizer
    import palette_pkg::*;
#(
    parameter int CNT_W = 20
) (
    input logic                clk,
    input logic                rst,
    palette_quantizer_if.slave bus
);

    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

    logic [2:0] r_code_s;
    logic [2:0] g_code_s;
    logic [1:0] b_code_s;
    logic       r_exact_s;
    logic       g_exact_s;
    logic       b_exact_s;

    logic       s1_valid_q, s1_valid_d;
    logic [2:0] s1_r_q, s1_r_d;
    logic [2:0] s1_g_q, s1_g_d;
    logic [1:0] s1_b_q, s1_b_d;
    logic [2:0] s1_exact_q, s1_exact_d;
    logic       s1_sof_q, s1_sof_d;

    logic       s2_valid_q, s2_valid_d;
    pal_index_t s2_idx_q, s2_idx_d;
    logic       s2_exact_q, s2_exact_d;
    logic       s2_sof_q, s2_sof_d;

    logic [CNT_W-1:0] pix_q, pix_d;
    logic [CNT_W-1:0] exact_q, exact_d;

    logic s1_ready_s;
    logic s2_ready_s;
    logic in_fire_s;
    logic out_fire_s;

    palette_channel_quant #(.N(RG_N), .CW(3)) u_quant_r (
        .value_i (bus.in_rgb[23:16]),
        .thr_i   (RG_THR),
        .lvl_i   (RG_LVL),
        .code_o  (r_code_s),
        .exact_o (r_exact_s)
    );

    palette_channel_quant #(.N(RG_N), .CW(3)) u_quant_g (
        .value_i (bus.in_rgb[15:8]),
        .thr_i   (RG_THR),
        .lvl_i   (RG_LVL),
        .code_o  (g_code_s),
        .exact_o (g_exact_s)
    );

    palette_channel_quant #(.N(B_N), .CW(2)) u_quant_b (
        .value_i (bus.in_rgb[7:0]),
        .thr_i   (B_THR),
        .lvl_i   (B_LVL),
        .code_o  (b_code_s),
        .exact_o (b_exact_s)
    );

    // A stage may take new data when it is empty or its content leaves this cycle.
    assign s2_ready_s   = ~s2_valid_q | bus.out_ready;
    assign s1_ready_s   = ~s1_valid_q | s2_ready_s;
    assign bus.in_ready = s1_ready_s & ~rst;
    assign in_fire_s    = bus.in_valid & bus.in_ready;
    assign out_fire_s   = s2_valid_q & bus.out_ready;

    // Pipeline next-state: stage 1 captures channel codes, stage 2 packs the index.
    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_r_d     = s1_r_q;
        s1_g_d     = s1_g_q;
        s1_b_d     = s1_b_q;
        s1_exact_d = s1_exact_q;
        s1_sof_d   = s1_sof_q;
        s2_valid_d = s2_valid_q;
        s2_idx_d   = s2_idx_q;
        s2_exact_d = s2_exact_q;
        s2_sof_d   = s2_sof_q;

        if (s1_ready_s) begin
            s1_valid_d = in_fire_s;
        end else begin
            s1_valid_d = s1_valid_q;
        end

        if (in_fire_s) begin
            s1_r_d     = r_code_s;
            s1_g_d     = g_code_s;
            s1_b_d     = b_code_s;
            s1_exact_d = {r_exact_s, g_exact_s, b_exact_s};
            s1_sof_d   = bus.in_sof;
        end else begin
            s1_sof_d   = s1_sof_q;
        end

        if (s2_ready_s) begin
            s2_valid_d = s1_valid_q;
        end else begin
            s2_valid_d = s2_valid_q;
        end

        // Output fields only change when a real pixel moves in, so they hold under stall.
        if (s2_ready_s && s1_valid_q) begin
            s2_idx_d.r = s1_r_q;
            s2_idx_d.g = s1_g_q;
            s2_idx_d.b = s1_b_q;
            s2_exact_d = &s1_exact_q;
            s2_sof_d   = s1_sof_q;
        end else begin
            s2_sof_d   = s2_sof_q;
        end
    end

    // Frame statistics advance only on output transfers and saturate at all-ones.
    always_comb begin
        pix_d   = pix_q;
        exact_d = exact_q;
        if (out_fire_s) begin
            if (s2_sof_q) begin
                pix_d   = CNT_ONE;
                exact_d = s2_exact_q ? CNT_ONE : CNT_ZERO;
            end else begin
                if (pix_q != CNT_MAX) begin
                    pix_d = pix_q + CNT_ONE;
                end else begin
                    pix_d = pix_q;
                end
                if (s2_exact_q && (exact_q != CNT_MAX)) begin
                    exact_d = exact_q + CNT_ONE;
                end else begin
                    exact_d = exact_q;
                end
            end
        end else begin
            pix_d   = pix_q;
            exact_d = exact_q;
        end
    end

    // State registers; reset discards every in-flight pixel.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_r_q     <= 3'd0;
            s1_g_q     <= 3'd0;
            s1_b_q     <= 2'd0;
            s1_exact_q <= 3'b000;
            s1_sof_q   <= 1'b0;
            s2_valid_q <= 1'b0;
            s2_idx_q   <= pal_index_t'(8'h00);
            s2_exact_q <= 1'b0;
            s2_sof_q   <= 1'b0;
            pix_q      <= CNT_ZERO;
            exact_q    <= CNT_ZERO;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_r_q     <= s1_r_d;
            s1_g_q     <= s1_g_d;
            s1_b_q     <= s1_b_d;
            s1_exact_q <= s1_exact_d;
            s1_sof_q   <= s1_sof_d;
            s2_valid_q <= s2_valid_d;
            s2_idx_q   <= s2_idx_d;
            s2_exact_q <= s2_exact_d;
            s2_sof_q   <= s2_sof_d;
            pix_q      <= pix_d;
            exact_q    <= exact_d;
        end
    end

    assign bus.out_valid   = s2_valid_q;
    assign bus.out_index   = s2_idx_q;
    assign bus.out_exact   = s2_exact_q;
    assign bus.out_sof     = s2_sof_q;
    assign bus.pix_count   = pix_q;
    assign bus.exact_count = exact_q;

endmodule
